// File: rtl/cvm_pkg.sv
// Shared types and coin encodings for the vending controller.
package cvm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StDispense,
    StChange
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

endpackage

// File: rtl/cvm_vend_ctrl_if.sv
// Vending controller bus: coin/selection inputs, dispense and change handshakes, status.
interface cvm_vend_ctrl_if #(
  parameter int unsigned N_ITEMS  = 4,
  parameter int unsigned CREDIT_W = 8
);
  localparam int unsigned IW = (N_ITEMS > 2) ? $clog2(N_ITEMS) : 1;

  logic [1:0]          coin;
  logic                sel_valid;
  logic [IW-1:0]       sel_item;
  logic                sugar;
  logic                cancel;
  logic                dispense_valid;
  logic [IW-1:0]       dispense_item;
  logic                dispense_sugar;
  logic                dispense_ready;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;
  logic                change_ready;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                sel_err;
  logic                busy;

  modport slave (
    input  coin, sel_valid, sel_item, sugar, cancel, dispense_ready, change_ready,
    output dispense_valid, dispense_item, dispense_sugar, change_valid, change_amount,
    output credit, coin_reject, sel_err, busy
  );

  modport master (
    output coin, sel_valid, sel_item, sugar, cancel, dispense_ready, change_ready,
    input  dispense_valid, dispense_item, dispense_sugar, change_valid, change_amount,
    input  credit, coin_reject, sel_err, busy
  );

endinterface

// File: rtl/cvm_idle_timer.sv
// Clearable up-counter; o_tc holds high once TIMEOUT_CYC-1 is reached until cleared.
module cvm_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tc
);
  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tc = (r_cnt == TermCnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cvm_vend_ctrl.sv
// Multi-product vending controller: credit accumulation, selection, dispense and change.
module cvm_vend_ctrl
  import cvm_pkg::*;
#(
  parameter int unsigned N_ITEMS  = 4,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned COIN_V1  = 5,
  parameter int unsigned COIN_V2  = 10,
  parameter int unsigned COIN_V3  = 25,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd40, 8'd30, 8'd20, 8'd15},
  parameter int unsigned MAX_CREDIT  = 100,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic            i_clk,
  input logic            i_rst_n,
  cvm_vend_ctrl_if.slave io_bus
);
  localparam int unsigned IW = (N_ITEMS > 2) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned SW = CREDIT_W + 1;
  localparam logic [IW:0] NItemsExt = (IW + 1)'(N_ITEMS);
  localparam logic [SW-1:0] MaxSum = SW'(MAX_CREDIT);

  state_t              r_state, w_state_d;
  logic [CREDIT_W-1:0] r_credit, w_credit_d;
  logic [IW-1:0]       r_item, w_item_d;
  logic                r_sugar, w_sugar_d;
  logic                r_coin_rej, w_coin_rej_d;
  logic                r_sel_err, w_sel_err_d;
  logic                r_disp_valid, r_chg_valid, r_busy;

  logic [CREDIT_W-1:0] w_coin_val, w_price, w_after_sel;
  logic [SW-1:0]       w_sum_coin, w_sum_sel;
  logic                w_coin_ev, w_item_ok, w_afford, w_cancel_eff;
  logic                w_tmr_clr, w_tmr_tc;
  int unsigned         w_idx;

  always_comb begin
    unique case (io_bus.coin)
      COIN_1:  w_coin_val = CREDIT_W'(COIN_V1);
      COIN_2:  w_coin_val = CREDIT_W'(COIN_V2);
      COIN_3:  w_coin_val = CREDIT_W'(COIN_V3);
      default: w_coin_val = '0;
    endcase
  end

  assign w_coin_ev    = (io_bus.coin != COIN_NONE);
  assign w_idx        = 32'(io_bus.sel_item);
  assign w_item_ok    = ({1'b0, io_bus.sel_item} < NItemsExt);
  assign w_price      = w_item_ok ? PRICES[w_idx*CREDIT_W +: CREDIT_W] : '0;
  // Affordability is judged on credit before any same-cycle coin.
  assign w_afford     = w_item_ok && (r_credit >= w_price);
  assign w_after_sel  = r_credit - w_price;
  assign w_sum_coin   = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_sum_sel    = {1'b0, w_after_sel} + {1'b0, w_coin_val};
  assign w_cancel_eff = io_bus.cancel && (r_state == StCredit);

  // Any coin or selection counts as activity; the timer only runs while holding credit.
  assign w_tmr_clr = (r_state != StCredit) || w_coin_ev || io_bus.sel_valid;

  cvm_idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_tmr_clr),
    .o_tc   (w_tmr_tc)
  );

  always_comb begin
    w_state_d    = r_state;
    w_credit_d   = r_credit;
    w_item_d     = r_item;
    w_sugar_d    = r_sugar;
    w_coin_rej_d = 1'b0;
    w_sel_err_d  = 1'b0;
    unique case (r_state)
      StIdle, StCredit: begin
        if (io_bus.sel_valid && !w_cancel_eff && w_afford) begin
          w_item_d  = io_bus.sel_item;
          w_sugar_d = io_bus.sugar;
          w_state_d = StDispense;
          if (w_coin_ev && (w_sum_sel > MaxSum)) begin
            w_coin_rej_d = 1'b1;
            w_credit_d   = w_after_sel;
          end else begin
            w_credit_d = w_sum_sel[CREDIT_W-1:0];
          end
        end else begin
          w_sel_err_d = io_bus.sel_valid && !w_cancel_eff;
          if (w_coin_ev) begin
            if (w_sum_coin <= MaxSum) begin
              w_credit_d = w_sum_coin[CREDIT_W-1:0];
              w_state_d  = StCredit;
            end else begin
              w_coin_rej_d = 1'b1;
            end
          end
          if (w_cancel_eff ||
              (r_state == StCredit && w_tmr_tc && !w_coin_ev && !io_bus.sel_valid)) begin
            w_state_d = StChange;
          end
        end
      end
      StDispense: begin
        w_coin_rej_d = w_coin_ev;
        w_sel_err_d  = io_bus.sel_valid;
        if (io_bus.dispense_ready) begin
          w_state_d = (r_credit != '0) ? StChange : StIdle;
        end
      end
      StChange: begin
        w_coin_rej_d = w_coin_ev;
        w_sel_err_d  = io_bus.sel_valid;
        if (io_bus.change_ready) begin
          w_credit_d = '0;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_credit     <= '0;
      r_item       <= '0;
      r_sugar      <= 1'b0;
      r_coin_rej   <= 1'b0;
      r_sel_err    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_chg_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_credit     <= w_credit_d;
      r_item       <= w_item_d;
      r_sugar      <= w_sugar_d;
      r_coin_rej   <= w_coin_rej_d;
      r_sel_err    <= w_sel_err_d;
      r_disp_valid <= (w_state_d == StDispense);
      r_chg_valid  <= (w_state_d == StChange);
      r_busy       <= (w_state_d == StDispense) || (w_state_d == StChange);
    end
  end

  assign io_bus.dispense_valid = r_disp_valid;
  assign io_bus.dispense_item  = r_item;
  assign io_bus.dispense_sugar = r_sugar;
  assign io_bus.change_valid   = r_chg_valid;
  assign io_bus.change_amount  = r_credit;
  assign io_bus.credit         = r_credit;
  assign io_bus.coin_reject    = r_coin_rej;
  assign io_bus.sel_err        = r_sel_err;
  assign io_bus.busy           = r_busy;

endmodule

// File: tb/tb_cvm_vend_ctrl.sv
// Scoreboard bench for cvm_vend_ctrl: transaction-level reference model, queued expectations.
module tb_cvm_vend_ctrl;
  localparam int unsigned T    = 1000;
  localparam int unsigned MAXC = 100;

  typedef struct packed {
    logic [7:0] crd;
    logic       rej;
    logic       err;
    logic       dv;
    logic       cv;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cvm_vend_ctrl_if #(.N_ITEMS(4), .CREDIT_W(8)) bus ();

  cvm_vend_ctrl #(
    .N_ITEMS    (4),
    .CREDIT_W   (8),
    .COIN_V1    (5),
    .COIN_V2    (10),
    .COIN_V3    (25),
    .PRICES     ({8'd40, 8'd30, 8'd20, 8'd15}),
    .MAX_CREDIT (MAXC),
    .TIMEOUT_CYC(T)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_cyc[$];
  logic [2:0] q_disp[$];
  int   q_chg[$];
  bit   mon_en = 1'b0;
  bit   prev_dv = 1'b0;
  bit   prev_cv = 1'b0;

  // Reference model: money held, and which delivery (goods or change) is owed.
  int m_credit = 0;
  int m_quiet  = 0;
  bit m_owe_goods = 1'b0;
  bit m_owe_change = 1'b0;

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'd1: return 5;
      2'd2: return 10;
      2'd3: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic int price_of(input int i);
    case (i)
      0: return 15;
      1: return 20;
      2: return 30;
      default: return 40;
    endcase
  endfunction

  task automatic owe_change();
    m_owe_change = 1'b1;
    q_chg.push_back(m_credit);
  endtask

  task automatic model_step(input logic [1:0] c, input bit sv, input int si, input bit sg,
                            input bit cn, input bit dr, input bit cr,
                            output bit rej, output bit err);
    int v;
    bit holding;
    v = coin_value(c);
    rej = 1'b0;
    err = 1'b0;
    if (m_owe_goods) begin
      rej = (v != 0);
      err = sv;
      if (dr) begin
        m_owe_goods = 1'b0;
        if (m_credit > 0) owe_change();
      end
    end else if (m_owe_change) begin
      rej = (v != 0);
      err = sv;
      if (cr) begin
        m_owe_change = 1'b0;
        m_credit = 0;
      end
    end else begin
      holding = (m_credit > 0);
      if (sv && !(cn && holding) && si < 4 && m_credit >= price_of(si)) begin
        m_credit -= price_of(si);
        if (m_credit + v <= MAXC) m_credit += v;
        else rej = 1'b1;
        m_owe_goods = 1'b1;
        q_disp.push_back({si[1:0], sg});
      end else begin
        err = sv && !(cn && holding);
        if (v != 0) begin
          if (m_credit + v <= MAXC) m_credit += v;
          else rej = 1'b1;
        end
        if (cn && holding) begin
          owe_change();
        end else if (holding && v == 0 && !sv) begin
          m_quiet++;
          if (m_quiet >= int'(T)) owe_change();
        end
      end
    end
    if (m_owe_goods || m_owe_change || v != 0 || sv || m_credit == 0) m_quiet = 0;
  endtask

  task automatic cyc(input logic [1:0] c, input bit sv, input int si, input bit sg,
                     input bit cn, input bit dr, input bit cr);
    bit   rej, err;
    exp_t e;
    @(negedge clk);
    bus.coin           = c;
    bus.sel_valid      = sv;
    bus.sel_item       = 2'(si);
    bus.sugar          = sg;
    bus.cancel         = cn;
    bus.dispense_ready = dr;
    bus.change_ready   = cr;
    model_step(c, sv, si, sg, cn, dr, cr, rej, err);
    e.crd  = 8'(m_credit);
    e.rej  = rej;
    e.err  = err;
    e.dv   = m_owe_goods;
    e.cv   = m_owe_change;
    e.busy = m_owe_goods | m_owe_change;
    q_cyc.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: checks registered outputs one step after each driven cycle.
  always @(posedge clk) begin
    exp_t e, a;
    logic [2:0] d;
    int amt;
    #1;
    if (mon_en && q_cyc.size() > 0) begin
      e = q_cyc.pop_front();
      a = {bus.credit, bus.coin_reject, bus.sel_err, bus.dispense_valid, bus.change_valid,
           bus.busy};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL status @%0t: got crd=%0d rej=%0b err=%0b dv=%0b cv=%0b busy=%0b, want crd=%0d rej=%0b err=%0b dv=%0b cv=%0b busy=%0b",
                 $time, a.crd, a.rej, a.err, a.dv, a.cv, a.busy,
                 e.crd, e.rej, e.err, e.dv, e.cv, e.busy);
      end
      if (bus.dispense_valid === 1'b1 && !prev_dv) begin
        n_vec++;
        if (q_disp.size() == 0) begin
          n_err++;
          $display("FAIL dispense @%0t: got unexpected item=%0d, want no dispense", $time,
                   bus.dispense_item);
        end else begin
          d = q_disp.pop_front();
          if ({bus.dispense_item, bus.dispense_sugar} !== d) begin
            n_err++;
            $display("FAIL dispense @%0t: got item=%0d sugar=%0b, want item=%0d sugar=%0b",
                     $time, bus.dispense_item, bus.dispense_sugar, d[2:1], d[0]);
          end
        end
      end
      if (bus.change_valid === 1'b1 && !prev_cv) begin
        n_vec++;
        if (q_chg.size() == 0) begin
          n_err++;
          $display("FAIL change @%0t: got unexpected amount=%0d, want no change", $time,
                   bus.change_amount);
        end else begin
          amt = q_chg.pop_front();
          if (int'(bus.change_amount) != amt) begin
            n_err++;
            $display("FAIL change @%0t: got amount=%0d, want %0d", $time, bus.change_amount,
                     amt);
          end
        end
      end
      prev_dv = (bus.dispense_valid === 1'b1);
      prev_cv = (bus.change_valid === 1'b1);
    end
  end

  task automatic check_all_zero(input string name);
    logic [23:0] o;
    o = {bus.dispense_valid, bus.dispense_item, bus.dispense_sugar, bus.change_valid,
         bus.change_amount, bus.credit, bus.coin_reject, bus.sel_err, bus.busy};
    n_vec++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL %s: got outputs=%h, want 0", name, o);
    end
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (q_disp.size() != 0 || q_chg.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d dispense and %0d change still owed, want 0 and 0", name,
               q_disp.size(), q_chg.size());
    end
  endtask

  initial begin
    bus.coin = 2'd0;
    bus.sel_valid = 1'b0;
    bus.sel_item = '0;
    bus.sugar = 1'b0;
    bus.cancel = 1'b0;
    bus.dispense_ready = 1'b0;
    bus.change_ready = 1'b0;
    #22;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Exact payment with sugar, no change owed.
    cyc(2'd2, 0, 0, 0, 0, 0, 0);
    cyc(2'd2, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 1, 1, 0, 0, 0);
    idle(2);
    cyc(2'd0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Overpayment: dispense then change 35.
    cyc(2'd3, 0, 0, 0, 0, 0, 0);
    cyc(2'd3, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 0, 0, 0, 0, 0);
    cyc(2'd0, 0, 0, 0, 0, 1, 0);
    idle(1);
    cyc(2'd0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Insufficient credit, then cancel.
    cyc(2'd2, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 3, 0, 0, 0, 0);
    cyc(2'd0, 0, 0, 0, 1, 0, 0);
    cyc(2'd0, 0, 0, 0, 0, 0, 1);
    // Credit ceiling, coin during dispense.
    for (int i = 0; i < 4; i++) cyc(2'd3, 0, 0, 0, 0, 0, 0);
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 3, 0, 0, 0, 0);
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 0, 0, 0, 1, 0);
    cyc(2'd0, 0, 0, 0, 0, 0, 1);
    // Inactivity timeout, then a late coin restarting the timer.
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    idle(T);
    cyc(2'd0, 0, 0, 0, 0, 0, 1);
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    idle(T - 1);
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    idle(T + 2);
    cyc(2'd0, 0, 0, 0, 0, 0, 1);
    // Cancel beats a same-cycle affordable selection.
    cyc(2'd3, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 0, 1, 1, 0, 0);
    cyc(2'd0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc(c, $urandom_range(0, 99) < 15, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) < 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) cyc(2'd0, 0, 0, 0, 1, 1, 1);
    idle(2);
    @(posedge clk);
    #3;
    check_drained("deliveries_drained");

    // Asynchronous reset while a dispense is pending.
    cyc(2'd3, 0, 0, 0, 0, 0, 0);
    cyc(2'd0, 1, 2, 1, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_dispense");
    q_cyc.delete();
    q_disp.delete();
    q_chg.delete();
    m_credit = 0;
    m_quiet = 0;
    m_owe_goods = 1'b0;
    m_owe_change = 1'b0;
    prev_dv = 1'b0;
    prev_cv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc(2'd1, 0, 0, 0, 0, 0, 0);
    idle(2);
    @(posedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cvm_vend_ctrl.md
# cvm_vend_ctrl

Parametrised multi-product vending controller; successor to the fixed two-coin coffee FSM. Accumulates coin credit in a binary counter, accepts an item selection with optional sugar, and issues a dispense request and a change (refund) request over valid/ready handshakes. Adds cancel and an inactivity timeout. Sits between the debounced coin acceptor and the dispenser/change-hopper drivers.

## Interface
- N_ITEMS, 4, number of selectable products (≥2)
- CREDIT_W, 8, credit/price/change width
- COIN_V1 / COIN_V2 / COIN_V3, 5 / 10 / 25, value of coin codes 01 / 10 / 11
- PRICES, {8'd40,8'd30,8'd20,8'd15}, packed N_ITEMS×CREDIT_W; item i at [i*CREDIT_W +: CREDIT_W]
- MAX_CREDIT, 100, credit ceiling
- TIMEOUT_CYC, 1000, idle cycles in CREDIT before auto-refund
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- coin  in  2  00 none, else one coin per cycle (single-cycle pulse from acceptor)
- sel_valid  in  1  selection strobe
- sel_item  in  $clog2(N_ITEMS)  selected product
- sugar  in  1  sugar request, sampled with sel_valid
- cancel  in  1  refund request
- dispense_valid  out  1  dispense request
- dispense_item  out  $clog2(N_ITEMS)  product to dispense
- dispense_sugar  out  1  add sugar
- dispense_ready  in  1  dispenser accepts
- change_valid  out  1  change request
- change_amount  out  CREDIT_W  amount to return
- change_ready  in  1  hopper accepts
- credit  out  CREDIT_W  current credit
- coin_reject  out  1  one-cycle pulse: coin not credited
- sel_err  out  1  one-cycle pulse: selection refused
- busy  out  1  high in DISPENSE or CHANGE

## Operation
- States: IDLE (credit 0), CREDIT, DISPENSE, CHANGE.
- Coin (IDLE/CREDIT): if credit+value ≤ MAX_CREDIT, credit += value, IDLE→CREDIT; else coin_reject, credit unchanged. Coins in DISPENSE/CHANGE: coin_reject.
- sel_valid (IDLE/CREDIT): sel_item ≥ N_ITEMS or credit (pre-coin value) < price → sel_err, no state change. Otherwise latch item and sugar, credit −= price, → DISPENSE. A same-cycle coin is still credited (overflow check on credit+value−price).
- Price 0 items dispense from IDLE.
- cancel (CREDIT): → CHANGE. cancel beats sel_valid in the same cycle. cancel in IDLE ignored; in DISPENSE/CHANGE ignored.
- Timeout: counter clears on entry to CREDIT and on every coin or sel_valid; reaching TIMEOUT_CYC−1 in CREDIT → CHANGE.
- DISPENSE: dispense_valid=1, item/sugar stable until dispense_valid&dispense_ready; then credit>0 → CHANGE, else → IDLE.
- CHANGE: change_valid=1, change_amount=credit, stable until change_valid&change_ready; then credit=0, → IDLE.
- sel_valid in DISPENSE/CHANGE: sel_err.

## Timing
- Reset: state IDLE, credit 0, timer 0; all outputs 0.
- All outputs registered. credit updates the cycle after the coin. dispense_valid rises one cycle after accepted sel_valid. coin_reject/sel_err pulse one cycle after cause.
- valid never drops without ready; ready while valid low has no effect. Handshake completes in the cycle ready is sampled high; valid low next cycle.
- Reset mid-handshake: valid drops immediately, credit lost (acceptable; field reset).
- Credit never exceeds MAX_CREDIT, never underflows.

## Structure
- Package cvm_pkg: state enum, coin code constants (COIN_NONE/COIN_1/COIN_2/COIN_3).
- Sub-module cvm_idle_timer: clearable up-counter with terminal pulse, width $clog2(TIMEOUT_CYC).
- Price lookup and coin decode inline in cvm_vend_ctrl.

## Test plan
- Coins 10,10 then sel item1 (20), sugar=1 -> dispense_valid, item 1, sugar 1; credit 0; after ready -> IDLE, no change_valid.
- Coins 25,25 then sel item0 (15) -> dispense, credit 35; after dispense_ready -> change_valid, change_amount 35; after change_ready credit 0.
- Coin 10 then sel item3 (40) -> sel_err pulse, credit stays 10; then cancel -> change_amount 10.
- Coins 25×4 (100) then coin 5 -> coin_reject, credit 100; coin during DISPENSE -> coin_reject.
- Coin 5 then TIMEOUT_CYC idle cycles -> change_valid, amount 5; coin at cycle 999 restarts timer.
- cancel and sel_valid same cycle with sufficient credit -> CHANGE wins; rst low while dispense_valid -> all outputs 0 asynchronously.
